// File: rtl/uart_pkg.sv
// Shared definitions for the extended UART receiver.
//   uart_rx_state_e   : receiver FSM states
//   uart_rx_status_t  : per-word error status carried with the held word
//   uart_rx_cfg_legal : parameter legality check used at elaboration
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } uart_rx_state_e;

  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic break_det;
  } uart_rx_status_t;

  localparam int UART_DOUT_W = 8;

  function automatic bit uart_rx_cfg_legal(input int dbit, input int os,
                                           input int par_en, input int par_odd,
                                           input int stop_bits);
    return (dbit >= 5) && (dbit <= 8) &&
           (os >= 8) && (os <= 32) && ((os % 2) == 0) &&
           ((par_en == 0) || (par_en == 1)) &&
           ((par_odd == 0) || (par_odd == 1)) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the UART receiver.
//   clk, reset : clock, asynchronous active-high reset
//   rx         : asynchronous serial line (idle high)
//   s_tick     : oversample strobe; shifts the vote window
//   rx_sync    : rx after a 2-flop synchroniser
//   rx_vote    : majority of the last 3 tick-sampled rx_sync values
module uart_rx_sampler (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic s_tick,
  output logic rx_sync,
  output logic rx_vote
);

  logic [1:0] sync_q;
  logic [2:0] tap_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      tap_q  <= '1;
    end else begin
      sync_q <= {sync_q[0], rx};
      if (s_tick) tap_q <= {tap_q[1:0], sync_q[1]};
    end
  end

  assign rx_sync = sync_q[1];
  assign rx_vote = (tap_q[0] & tap_q[1]) | (tap_q[0] & tap_q[2]) |
                   (tap_q[1] & tap_q[2]);

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver with majority-vote sampling, optional parity,
// 1/2 stop bits, break/framing/parity/overrun status and a one-entry
// valid/ready holding register.
//   clk, reset  : clock, asynchronous active-high reset
//   rx          : serial input, idle high, LSB first
//   s_tick      : OVERSAMPLE x baud strobe
//   m_ready     : consumer accepts the held word
//   m_valid     : holding register full
//   dout        : held data, zero-extended above DBIT
//   parity_err, frame_err, break_det : status of the held word
//   overrun     : sticky, a completed frame was dropped; cleared by handshake
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  input  logic       m_ready,
  output logic       m_valid,
  output logic [7:0] dout,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det,
  output logic       overrun
);

  generate
    if (!uart_rx_cfg_legal(DBIT, OVERSAMPLE, PARITY_EN, PARITY_ODD, STOP_BITS)) begin : g_bad_cfg
      $error("uart_rx_ext: illegal parameter combination");
    end
  endgenerate

  localparam int              TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]   TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]   TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]      BIT_LAST  = 3'(DBIT - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic            ODD       = (PARITY_ODD != 0);

  logic rx_sync, rx_vote;

  uart_rx_sampler u_sampler (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .s_tick  (s_tick),
    .rx_sync (rx_sync),
    .rx_vote (rx_vote)
  );

  uart_rx_state_e  state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            done;
  logic            frame_now;
  uart_rx_status_t done_status;
  uart_rx_status_t status_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    done        = 1'b0;
    frame_now   = 1'b0;
    done_status = '0;
    case (state_q)
      IDLE: begin
        if (!rx_sync) begin
          tick_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            if (!rx_vote) begin
              state_d = DATA;
              bit_d   = '0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shreg_d = {rx_vote, shreg_q[DBIT-1:1]};
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            perr_d  = ((^shreg_q) ^ rx_vote) != ODD;
            bit_d   = '0;
            state_d = STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d    = '0;
            frame_now = ferr_q | ~rx_vote;
            ferr_d    = frame_now;
            if (bit_q == STOP_LAST) begin
              // Completion is mid-stop-bit so a back-to-back start edge is seen.
              done                   = 1'b1;
              bit_d                  = '0;
              done_status.parity_err = perr_q;
              done_status.frame_err  = frame_now;
              done_status.break_det  = frame_now && (shreg_q == '0);
              state_d = done_status.break_det ? BRK_WAIT : IDLE;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      BRK_WAIT: begin
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A completion that coincides with a handshake refills the register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid  <= 1'b0;
      dout     <= '0;
      status_q <= '0;
      overrun  <= 1'b0;
    end else if (done) begin
      if (!m_valid || m_ready) begin
        m_valid  <= 1'b1;
        dout     <= UART_DOUT_W'(shreg_q);
        status_q <= done_status;
      end else begin
        overrun <= 1'b1;
      end
    end else if (m_valid && m_ready) begin
      m_valid  <= 1'b0;
      overrun  <= 1'b0;
      status_q <= '0;
    end
  end

  assign parity_err = status_q.parity_err;
  assign frame_err  = status_q.frame_err;
  assign break_det  = status_q.break_det;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed testbench for uart_rx_ext: three instances (8N1, 7E1, 8N2).
module tb_uart_rx_ext;

  localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clk

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_tick = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic m_ready_a = 1'b0, m_ready_b = 1'b0, m_ready_c = 1'b0;
  logic m_valid_a, m_valid_b, m_valid_c;
  logic [7:0] dout_a, dout_b, dout_c;
  logic pe_a, pe_b, pe_c, fe_a, fe_b, fe_c, bd_a, bd_b, bd_c, ov_a, ov_b, ov_c;

  int n_checks = 0;
  int n_errors = 0;

  int cnt_a = 0, cnt_b = 0, cnt_c = 0;
  logic [7:0] last_dout_a = '0, prev_dout_a = '0, last_dout_b = '0, last_dout_c = '0;
  logic last_pe_a = 0, last_fe_a = 0, last_bd_a = 0;
  logic last_pe_b = 0, last_fe_b = 0, last_bd_b = 0;
  logic last_pe_c = 0, last_fe_c = 0, last_bd_c = 0;

  uart_rx_ext #(.DBIT(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .s_tick(s_tick), .m_ready(m_ready_a),
    .m_valid(m_valid_a), .dout(dout_a), .parity_err(pe_a), .frame_err(fe_a),
    .break_det(bd_a), .overrun(ov_a));

  uart_rx_ext #(.DBIT(7), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .s_tick(s_tick), .m_ready(m_ready_b),
    .m_valid(m_valid_b), .dout(dout_b), .parity_err(pe_b), .frame_err(fe_b),
    .break_det(bd_b), .overrun(ov_b));

  uart_rx_ext #(.DBIT(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_c (
    .clk(clk), .reset(reset), .rx(rx_c), .s_tick(s_tick), .m_ready(m_ready_c),
    .m_valid(m_valid_c), .dout(dout_c), .parity_err(pe_c), .frame_err(fe_c),
    .break_det(bd_c), .overrun(ov_c));

  always #5 clk = ~clk;

  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      s_tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  // Capture every accepted word.
  always @(negedge clk) begin
    if (m_valid_a && m_ready_a) begin
      cnt_a++; prev_dout_a = last_dout_a; last_dout_a = dout_a;
      last_pe_a = pe_a; last_fe_a = fe_a; last_bd_a = bd_a;
    end
    if (m_valid_b && m_ready_b) begin
      cnt_b++; last_dout_b = dout_b; last_pe_b = pe_b; last_fe_b = fe_b; last_bd_b = bd_b;
    end
    if (m_valid_c && m_ready_c) begin
      cnt_c++; last_dout_c = dout_c; last_pe_c = pe_c; last_fe_c = fe_c; last_bd_c = bd_c;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_rx(input int which, input logic v);
    case (which)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic hold_bit(input int which, input logic v, input logic glitch);
    drive_rx(which, v);
    if (glitch) begin
      wait_clk(24);
      drive_rx(which, ~v);
      wait_clk(4);
      drive_rx(which, v);
      wait_clk(BIT_CLK - 28);
    end else begin
      wait_clk(BIT_CLK);
    end
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input int nbits,
                            input bit par_en, input logic par_bit, input logic stop1,
                            input int nstop, input logic [7:0] glitch_mask);
    hold_bit(which, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) hold_bit(which, data[i], glitch_mask[i]);
    if (par_en) hold_bit(which, par_bit, 1'b0);
    hold_bit(which, stop1, 1'b0);
    for (int i = 1; i < nstop; i++) hold_bit(which, 1'b1, 1'b0);
    drive_rx(which, 1'b1);
  endtask

  task automatic test_reset;
    wait_clk(5);
    n_checks++; if (m_valid_a !== 1'b0) begin n_errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid_a); end
    n_checks++; if (dout_a !== 8'h00) begin n_errors++; $display("FAIL reset_dout: got %h expected 00", dout_a); end
    n_checks++; if ({pe_a, fe_a, bd_a, ov_a} !== 4'b0000) begin n_errors++; $display("FAIL reset_flags: got %b expected 0000", {pe_a, fe_a, bd_a, ov_a}); end
    reset = 1'b0;
    wait_clk(40);
    n_checks++; if (m_valid_a !== 1'b0 || m_valid_b !== 1'b0 || m_valid_c !== 1'b0) begin n_errors++; $display("FAIL idle_no_valid: got %b%b%b expected 000", m_valid_a, m_valid_b, m_valid_c); end
  endtask

  task automatic test_basic;
    logic [7:0] pats [3];
    int c0;
    pats[0] = 8'hA5; pats[1] = 8'h00; pats[2] = 8'hFF;
    m_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c0 = cnt_a;
      send_frame(0, pats[i], 8, 0, 1'b0, 1'b1, 1, 8'h00);
      wait_clk(BIT_CLK);
      n_checks++; if (cnt_a !== c0 + 1) begin n_errors++; $display("FAIL basic_count[%0d]: got %0d expected %0d", i, cnt_a, c0 + 1); end
      n_checks++; if (last_dout_a !== pats[i]) begin n_errors++; $display("FAIL basic_dout[%0d]: got %h expected %h", i, last_dout_a, pats[i]); end
      n_checks++; if ({last_pe_a, last_fe_a, last_bd_a} !== 3'b000) begin n_errors++; $display("FAIL basic_flags[%0d]: got %b expected 000", i, {last_pe_a, last_fe_a, last_bd_a}); end
    end
    n_checks++; if (m_valid_a !== 1'b0) begin n_errors++; $display("FAIL basic_drained: got %b expected 0", m_valid_a); end
  endtask

  task automatic test_parity;
    // {data, parity bit sent, expected parity_err} for 7-bit even parity
    logic [7:0] d [4];
    logic       p [4];
    logic       e [4];
    int c0;
    d[0] = 8'h41; p[0] = 1'b1; e[0] = 1'b1;
    d[1] = 8'h41; p[1] = 1'b0; e[1] = 1'b0;
    d[2] = 8'h7F; p[2] = 1'b1; e[2] = 1'b0;
    d[3] = 8'h7F; p[3] = 1'b0; e[3] = 1'b1;
    m_ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c0 = cnt_b;
      send_frame(1, d[i], 7, 1, p[i], 1'b1, 1, 8'h00);
      wait_clk(BIT_CLK);
      n_checks++; if (cnt_b !== c0 + 1) begin n_errors++; $display("FAIL parity_count[%0d]: got %0d expected %0d", i, cnt_b, c0 + 1); end
      n_checks++; if (last_dout_b !== d[i]) begin n_errors++; $display("FAIL parity_dout[%0d]: got %h expected %h", i, last_dout_b, d[i]); end
      n_checks++; if (last_pe_b !== e[i]) begin n_errors++; $display("FAIL parity_err[%0d]: got %b expected %b", i, last_pe_b, e[i]); end
      n_checks++; if (last_fe_b !== 1'b0) begin n_errors++; $display("FAIL parity_frame[%0d]: got %b expected 0", i, last_fe_b); end
    end
  endtask

  task automatic test_false_start;
    int c0;
    m_ready_a = 1'b1;
    c0 = cnt_a;
    drive_rx(0, 1'b0);
    wait_clk(16);
    drive_rx(0, 1'b1);
    wait_clk(3 * BIT_CLK);
    n_checks++; if (cnt_a !== c0) begin n_errors++; $display("FAIL false_start_word: got %0d words expected 0", cnt_a - c0); end
    send_frame(0, 8'h3C, 8, 0, 1'b0, 1'b1, 1, 8'h00);
    wait_clk(BIT_CLK);
    n_checks++; if (cnt_a !== c0 + 1) begin n_errors++; $display("FAIL false_start_next_count: got %0d expected %0d", cnt_a, c0 + 1); end
    n_checks++; if (last_dout_a !== 8'h3C) begin n_errors++; $display("FAIL false_start_next_dout: got %h expected 3c", last_dout_a); end
  endtask

  task automatic test_back_to_back;
    int c0;
    m_ready_a = 1'b1;
    c0 = cnt_a;
    send_frame(0, 8'h12, 8, 0, 1'b0, 1'b1, 1, 8'h00);
    send_frame(0, 8'h34, 8, 0, 1'b0, 1'b1, 1, 8'h00);
    wait_clk(BIT_CLK);
    n_checks++; if (cnt_a !== c0 + 2) begin n_errors++; $display("FAIL b2b_count: got %0d expected %0d", cnt_a, c0 + 2); end
    n_checks++; if ({prev_dout_a, last_dout_a} !== 16'h1234) begin n_errors++; $display("FAIL b2b_dout: got %h expected 1234", {prev_dout_a, last_dout_a}); end
  endtask

  task automatic test_overrun;
    m_ready_a = 1'b0;
    send_frame(0, 8'h11, 8, 0, 1'b0, 1'b1, 1, 8'h00);
    wait_clk(32);
    send_frame(0, 8'h22, 8, 0, 1'b0, 1'b1, 1, 8'h00);
    wait_clk(BIT_CLK);
    n_checks++; if (m_valid_a !== 1'b1) begin n_errors++; $display("FAIL overrun_valid: got %b expected 1", m_valid_a); end
    n_checks++; if (dout_a !== 8'h11) begin n_errors++; $display("FAIL overrun_dout: got %h expected 11", dout_a); end
    n_checks++; if (ov_a !== 1'b1) begin n_errors++; $display("FAIL overrun_flag: got %b expected 1", ov_a); end
    m_ready_a = 1'b1;
    wait_clk(1);
    m_ready_a = 1'b0;
    n_checks++; if (m_valid_a !== 1'b0) begin n_errors++; $display("FAIL overrun_clear_valid: got %b expected 0", m_valid_a); end
    n_checks++; if (ov_a !== 1'b0) begin n_errors++; $display("FAIL overrun_clear_flag: got %b expected 0", ov_a); end
  endtask

  task automatic test_break;
    int c0;
    m_ready_a = 1'b1;
    c0 = cnt_a;
    drive_rx(0, 1'b0);
    wait_clk(3 * 10 * BIT_CLK);
    n_checks++; if (cnt_a !== c0 + 1) begin n_errors++; $display("FAIL break_count: got %0d expected %0d", cnt_a, c0 + 1); end
    n_checks++; if (last_dout_a !== 8'h00) begin n_errors++; $display("FAIL break_dout: got %h expected 00", last_dout_a); end
    n_checks++; if ({last_fe_a, last_bd_a} !== 2'b11) begin n_errors++; $display("FAIL break_flags: got %b expected 11", {last_fe_a, last_bd_a}); end
    drive_rx(0, 1'b1);
    wait_clk(2 * BIT_CLK);
    n_checks++; if (cnt_a !== c0 + 1) begin n_errors++; $display("FAIL break_release_count: got %0d expected %0d", cnt_a, c0 + 1); end
    send_frame(0, 8'h5A, 8, 0, 1'b0, 1'b1, 1, 8'h00);
    wait_clk(BIT_CLK);
    n_checks++; if (cnt_a !== c0 + 2) begin n_errors++; $display("FAIL break_next_count: got %0d expected %0d", cnt_a, c0 + 2); end
    n_checks++; if ({last_dout_a, last_fe_a, last_bd_a} !== {8'h5A, 2'b00}) begin n_errors++; $display("FAIL break_next_word: got %h/%b%b expected 5a/00", last_dout_a, last_fe_a, last_bd_a); end
  endtask

  task automatic test_two_stop_glitch;
    int c0;
    m_ready_c = 1'b1;
    c0 = cnt_c;
    send_frame(2, 8'hF0, 8, 0, 1'b0, 1'b1, 2, 8'h81);
    wait_clk(BIT_CLK);
    n_checks++; if (cnt_c !== c0 + 1) begin n_errors++; $display("FAIL glitch_count: got %0d expected %0d", cnt_c, c0 + 1); end
    n_checks++; if (last_dout_c !== 8'hF0) begin n_errors++; $display("FAIL glitch_dout: got %h expected f0", last_dout_c); end
    n_checks++; if (last_fe_c !== 1'b0) begin n_errors++; $display("FAIL glitch_frame: got %b expected 0", last_fe_c); end
    // first of two stop bits low: framing error, not a break
    send_frame(2, 8'hF0, 8, 0, 1'b0, 1'b0, 2, 8'h00);
    wait_clk(BIT_CLK);
    n_checks++; if (cnt_c !== c0 + 2) begin n_errors++; $display("FAIL stop1_count: got %0d expected %0d", cnt_c, c0 + 2); end
    n_checks++; if ({last_dout_c, last_fe_c, last_bd_c} !== {8'hF0, 2'b10}) begin n_errors++; $display("FAIL stop1_word: got %h/%b%b expected f0/10", last_dout_c, last_fe_c, last_bd_c); end
  endtask

  task automatic test_reset_mid;
    int c0;
    m_ready_a = 1'b0;
    send_frame(0, 8'h77, 8, 0, 1'b0, 1'b1, 1, 8'h00);
    wait_clk(32);
    n_checks++; if ({m_valid_a, dout_a} !== {1'b1, 8'h77}) begin n_errors++; $display("FAIL pre_reset_word: got %b/%h expected 1/77", m_valid_a, dout_a); end
    hold_bit(0, 1'b0, 1'b0);
    hold_bit(0, 1'b1, 1'b0);
    hold_bit(0, 1'b1, 1'b0);
    wait_clk(20);
    reset = 1'b1;
    wait_clk(3);
    n_checks++; if ({m_valid_a, dout_a, pe_a, fe_a, bd_a, ov_a} !== 13'h0) begin n_errors++; $display("FAIL reset_mid_outputs: got %b/%h/%b expected 0/00/0000", m_valid_a, dout_a, {pe_a, fe_a, bd_a, ov_a}); end
    drive_rx(0, 1'b1);
    reset = 1'b0;
    wait_clk(2 * BIT_CLK);
    n_checks++; if (m_valid_a !== 1'b0) begin n_errors++; $display("FAIL reset_mid_residue: got %b expected 0", m_valid_a); end
    m_ready_a = 1'b1;
    c0 = cnt_a;
    send_frame(0, 8'hC3, 8, 0, 1'b0, 1'b1, 1, 8'h00);
    wait_clk(BIT_CLK);
    n_checks++; if (cnt_a !== c0 + 1) begin n_errors++; $display("FAIL reset_mid_next_count: got %0d expected %0d", cnt_a, c0 + 1); end
    n_checks++; if ({last_dout_a, last_fe_a} !== {8'hC3, 1'b0}) begin n_errors++; $display("FAIL reset_mid_next_word: got %h/%b expected c3/0", last_dout_a, last_fe_a); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_false_start;
    test_back_to_back;
    test_overrun;
    test_break;
    test_two_stop_glitch;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised UART receiver for the peripheral bus. It takes the same oversampling `s_tick` as the existing receiver and adds configurable data width, optional parity, 1 or 2 stop bits, and an input synchroniser with 3-sample majority vote. It reports framing, parity, break and overrun status and presents each received word on a valid/ready output held in a one-entry holding register. It sits between the pad-side `rx` line and the UART register block / RX FIFO.

## Interface
- `DBIT`, 8: data bits per frame, legal 5..8.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit, even, legal 8..32.
- `PARITY_EN`, 0: 1 = a parity bit follows the data.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: 1 or 2.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `rx` in 1: serial line, asynchronous, idle high.
- `s_tick` in 1: single-cycle oversample strobe, `OVERSAMPLE`×baud.
- `m_ready` in 1: consumer accepts the word.
- `m_valid` out 1: holding register full.
- `dout` out 8: received data, LSB first on the line; bits above `DBIT` are 0.
- `parity_err` out 1: parity mismatch for the held word.
- `frame_err` out 1: a stop bit was sampled low for the held word.
- `break_det` out 1: the held word is a break.
- `overrun` out 1: sticky; a completed frame was dropped. Cleared by a handshake.

## Operation
- Synchroniser: 2 flops on `rx`. On each `s_tick`, a 3-deep shift register captures the synchronised value. The sampled bit is the majority of the 3.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT. Tick counter is `$clog2(OVERSAMPLE)` bits. Bit counter is 3 bits.
- IDLE: when the synchronised `rx` is 0, clear the tick counter and go to START. No `s_tick` is needed to leave IDLE.
- START: count `s_tick`. At count `OVERSAMPLE/2-1`:
  - majority 0: clear counter, go to DATA.
  - majority 1: false start; return to IDLE with no output.
- DATA: sample each bit when the counter reaches `OVERSAMPLE-1`, then clear the counter. Shift the bit in at MSB position `DBIT-1` (right shift). After `DBIT` bits, go to PARITY if `PARITY_EN`=1, else to STOP.
- PARITY: sample one bit. Error when the XOR of the data and parity bits ≠ `PARITY_ODD`.
- STOP: sample `STOP_BITS` bits. Any low sample sets the frame error. Completion happens on the `s_tick` that samples the last stop bit:
  - If frame error and data = 0, set break and go to BRK_WAIT.
  - Otherwise go to IDLE.
- BRK_WAIT: stay until the synchronised `rx` = 1, then go to IDLE. No further words are produced during this state.
- Holding register, on completion:
  - If `m_valid`=0, or `m_valid`&`m_ready` in the same cycle: load `dout` and the 3 error flags, set `m_valid`.
  - Otherwise: drop the new word, keep the old word, set `overrun`.
- Handshake: `m_valid`&`m_ready` with no completion in that cycle clears `m_valid` and `overrun`. The error flags stay valid only while `m_valid`=1.
- Reset, including mid-frame: FSM goes to IDLE, counters clear, the synchroniser loads 1s, and all outputs go to 0.

## Timing
- `rx` reaches the FSM 2 clk after the pin. IDLE→START takes 1 clk after that.
- Sampling is at mid-bit: `OVERSAMPLE/2` ticks after the detected falling edge, then every `OVERSAMPLE` ticks.
- `m_valid` rises on the clk edge after the completing `s_tick` cycle, i.e. 1 clk registered latency.
- A frame with parity and 2 stop bits completes `(1.5+DBIT+1+1)·OVERSAMPLE` ticks after the start edge.
- A new start bit can be detected in the cycle after returning to IDLE. Consecutive frames with no idle gap are supported, because completion occurs mid-stop-bit.
- `m_valid`, `dout` and the flags are all registered. No combinational path runs from `m_ready` to any output.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state_e` enum.
  - `uart_rx_status_t` struct {parity_err, frame_err, break_det}.
  - Parameter legality checks as localparams/asserts.
- Sub-module `uart_rx_sampler`: 2-flop synchroniser, 3-tap shift register and majority vote. Outputs `rx_sync` and `rx_vote`.

## Test plan
- 8N1, OVERSAMPLE=16, send 0xA5, `m_ready`=1 → one `m_valid` pulse with `dout`=0xA5 and all flags 0.
- DBIT=7, even parity, send 0x41 with parity bit forced to 1 → `dout`=0x41, `parity_err`=1, `frame_err`=0.
- `rx` low for 4 ticks then high → no `m_valid`, FSM back in IDLE, next frame 0x3C received correctly.
- `m_ready`=0, send 0x11 then 0x22 → `dout` holds 0x11 and `overrun`=1. Asserting `m_ready` for 1 cycle → `m_valid`=0 and `overrun`=0.
- `rx` held low for 3 frame times → single word with `dout`=0x00, `frame_err`=1, `break_det`=1, no further words until `rx` high. Next frame 0x5A received correctly.
- 2 stop bits, 1-tick glitch on a data bit mid-sample (vote window) → correct data 0xF0. Assert reset mid-DATA → all outputs 0, and a frame sent after reset release is received intact.
